// File: rtl/lockin_frame_accumulator.sv
// Lock-in frame accumulator: sums signed X/Y products over frames of n_samples and
// emits 64-bit sums plus shifted/saturated 32-bit results with one-cycle strobes.
module lockin_frame_accumulator #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              reset_from_control,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_x,
    input  logic [DATA_W-1:0] sample_y,
    input  logic [31:0]       n_samples,
    input  logic [31:0]       n_frames,
    input  logic [5:0]        shift,
    output logic [ACC_W-1:0]  result_0_64_bit,
    output logic [ACC_W-1:0]  result_1_64_bit,
    output logic              result_0_64_bit_valid,
    output logic              result_1_64_bit_valid,
    output logic [31:0]       result_0_32_bit,
    output logic [31:0]       result_1_32_bit,
    output logic              result_0_32_bit_valid,
    output logic              result_1_32_bit_valid,
    output logic              calculo_finalizado,
    output logic [31:0]       frame_count,
    output logic              overflow
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned RES_W = 32;
    localparam int unsigned SH_W  = 6;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   nsamp_q, nsamp_d;
    logic [CNT_W-1:0]   nframes_q, nframes_d;
    logic [SH_W-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [ACC_W-1:0]   res0_64_q, res0_64_d, res1_64_q, res1_64_d;
    logic [RES_W-1:0]   res0_32_q, res0_32_d, res1_32_q, res1_32_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   ext_x_c, ext_y_c, sum_x_c, sum_y_c;
    logic               ovf_x_c, ovf_y_c;

    // Arithmetic shift then clamp to the signed 32-bit range.
    function automatic logic [RES_W-1:0] sat32(input logic [ACC_W-1:0] v,
                                               input logic [SH_W-1:0]  sh);
        logic [ACC_W-1:0]     s;
        logic [ACC_W-RES_W:0] hi;
        s  = ACC_W'($signed(v) >>> sh);
        hi = s[ACC_W-1:RES_W-1];
        if ((&hi) || !(|hi)) return s[RES_W-1:0];
        else if (s[ACC_W-1]) return RES_W'(32'h8000_0000);
        else                 return RES_W'(32'h7FFF_FFFF);
    endfunction

    assign ext_x_c = {{(ACC_W-DATA_W){sample_x[DATA_W-1]}}, sample_x};
    assign ext_y_c = {{(ACC_W-DATA_W){sample_y[DATA_W-1]}}, sample_y};
    assign sum_x_c = acc_x_q + ext_x_c;
    assign sum_y_c = acc_y_q + ext_y_c;
    assign ovf_x_c = (acc_x_q[ACC_W-1] == ext_x_c[ACC_W-1]) && (sum_x_c[ACC_W-1] != acc_x_q[ACC_W-1]);
    assign ovf_y_c = (acc_y_q[ACC_W-1] == ext_y_c[ACC_W-1]) && (sum_y_c[ACC_W-1] != acc_y_q[ACC_W-1]);

    // Next-state and datapath update; clear from control has top priority.
    always_comb begin
        state_d   = state_q;
        nsamp_d   = nsamp_q;
        nframes_d = nframes_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        res0_64_d = res0_64_q;
        res1_64_d = res1_64_q;
        res0_32_d = res0_32_q;
        res1_32_d = res1_32_q;
        valid_d   = 1'b0;
        fcnt_d    = fcnt_q;
        ovf_d     = ovf_q;

        if (reset_from_control) begin
            state_d   = S_IDLE;
            nsamp_d   = '0;
            nframes_d = '0;
            shift_d   = '0;
            cnt_d     = '0;
            acc_x_d   = '0;
            acc_y_d   = '0;
            res0_64_d = '0;
            res1_64_d = '0;
            res0_32_d = '0;
            res1_32_d = '0;
            fcnt_d    = '0;
            ovf_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d   = S_ACCUM;
                        nsamp_d   = (n_samples == CNT_W'(0)) ? CNT_W'(1) : n_samples;
                        nframes_d = n_frames;
                        shift_d   = shift;
                        cnt_d     = '0;
                        acc_x_d   = '0;
                        acc_y_d   = '0;
                        fcnt_d    = '0;
                    end
                end
                S_ACCUM: begin
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else if (sample_valid) begin
                        if (ovf_x_c || ovf_y_c) ovf_d = 1'b1;
                        if (cnt_q == nsamp_q - CNT_W'(1)) begin
                            res0_64_d = sum_x_c;
                            res1_64_d = sum_y_c;
                            res0_32_d = sat32(sum_x_c, shift_q);
                            res1_32_d = sat32(sum_y_c, shift_q);
                            valid_d   = 1'b1;
                            acc_x_d   = '0;
                            acc_y_d   = '0;
                            cnt_d     = '0;
                            fcnt_d    = fcnt_q + CNT_W'(1);
                            if ((nframes_q != CNT_W'(0)) && (fcnt_q + CNT_W'(1) == nframes_q))
                                state_d = S_DONE;
                        end else begin
                            acc_x_d = sum_x_c;
                            acc_y_d = sum_y_c;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!enable) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            nsamp_q   <= '0;
            nframes_q <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            res0_64_q <= '0;
            res1_64_q <= '0;
            res0_32_q <= '0;
            res1_32_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            fcnt_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            nsamp_q   <= nsamp_d;
            nframes_q <= nframes_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            res0_64_q <= res0_64_d;
            res1_64_q <= res1_64_d;
            res0_32_q <= res0_32_d;
            res1_32_q <= res1_32_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            fcnt_q    <= fcnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign result_0_64_bit       = res0_64_q;
    assign result_1_64_bit       = res1_64_q;
    assign result_0_32_bit       = res0_32_q;
    assign result_1_32_bit       = res1_32_q;
    assign result_0_64_bit_valid = valid_q;
    assign result_1_64_bit_valid = valid_q;
    assign result_0_32_bit_valid = valid_q;
    assign result_1_32_bit_valid = valid_q;
    assign calculo_finalizado    = done_q;
    assign frame_count           = fcnt_q;
    assign overflow              = ovf_q;

endmodule

// File: tb/tb_lockin_frame_accumulator.sv
// Directed bench for lockin_frame_accumulator; a narrow-accumulator instance
// shares the stimulus so the overflow flag can be reached in a few samples.
module tb_lockin_frame_accumulator;

    logic        clk = 1'b0;
    logic        reset_n, enable, rfc, sv;
    logic [31:0] sx, sy, ns, nf;
    logic [5:0]  sh;

    logic [63:0] a_r0_64, a_r1_64;
    logic [31:0] a_r0_32, a_r1_32, a_fc;
    logic        a_v0_64, a_v1_64, a_v0_32, a_v1_32, a_fin, a_ovf;

    logic [33:0] b_r0_64, b_r1_64;
    logic [31:0] b_r0_32, b_r1_32, b_fc;
    logic        b_v0_64, b_v1_64, b_v0_32, b_v1_32, b_fin, b_ovf;

    int ncmp = 0;
    int nfail = 0;
    int strb = 0;
    int vbad = 0;
    int s0;
    logic [31:0] vals [3];

    always #5 clk = ~clk;

    lockin_frame_accumulator #(.DATA_W(32), .ACC_W(64)) u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .reset_from_control(rfc),
        .sample_valid(sv), .sample_x(sx), .sample_y(sy),
        .n_samples(ns), .n_frames(nf), .shift(sh),
        .result_0_64_bit(a_r0_64), .result_1_64_bit(a_r1_64),
        .result_0_64_bit_valid(a_v0_64), .result_1_64_bit_valid(a_v1_64),
        .result_0_32_bit(a_r0_32), .result_1_32_bit(a_r1_32),
        .result_0_32_bit_valid(a_v0_32), .result_1_32_bit_valid(a_v1_32),
        .calculo_finalizado(a_fin), .frame_count(a_fc), .overflow(a_ovf)
    );

    lockin_frame_accumulator #(.DATA_W(32), .ACC_W(34)) u_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .reset_from_control(rfc),
        .sample_valid(sv), .sample_x(sx), .sample_y(sy),
        .n_samples(ns), .n_frames(nf), .shift(sh),
        .result_0_64_bit(b_r0_64), .result_1_64_bit(b_r1_64),
        .result_0_64_bit_valid(b_v0_64), .result_1_64_bit_valid(b_v1_64),
        .result_0_32_bit(b_r0_32), .result_1_32_bit(b_r1_32),
        .result_0_32_bit_valid(b_v0_32), .result_1_32_bit_valid(b_v1_32),
        .calculo_finalizado(b_fin), .frame_count(b_fc), .overflow(b_ovf)
    );

    // Strobe counter and four-valid agreement, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_v0_64) strb++;
        if (!((a_v0_64 == a_v1_64) && (a_v0_64 == a_v0_32) && (a_v0_64 == a_v1_32))) vbad++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vals[0] = 32'd3; vals[1] = 32'hFFFF_FFFB; vals[2] = 32'd7;
        reset_n = 1'b0; enable = 1'b0; rfc = 1'b0; sv = 1'b0;
        sx = '0; sy = '0; ns = '0; nf = '0; sh = '0;
        repeat (2) cyc();
        chk("rst_r0_64", a_r0_64, 64'd0);
        chk("rst_valid", {63'd0, a_v0_64}, 64'd0);
        chk("rst_fin", {63'd0, a_fin}, 64'd0);
        chk("rst_fc", {32'd0, a_fc}, 64'd0);
        chk("rst_ovf", {63'd0, a_ovf}, 64'd0);
        reset_n = 1'b1;
        cyc();

        // Single frame; the sample on the entry cycle must be ignored.
        ns = 32'd4; nf = 32'd1; sh = 6'd0;
        enable = 1'b1; sv = 1'b1; sx = 32'd100; sy = 32'd100;
        cyc();
        s0 = strb;
        for (int i = 1; i <= 4; i++) begin
            sx = 32'(i); sy = 32'hFFFF_FFFF;
            cyc();
        end
        chk("t1_r0_64", a_r0_64, 64'd10);
        chk("t1_r1_64", a_r1_64, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t1_r0_32", {32'd0, a_r0_32}, 64'd10);
        chk("t1_r1_32", {32'd0, a_r1_32}, 64'h0000_0000_FFFF_FFFC);
        chk("t1_valid", {63'd0, a_v0_64}, 64'd1);
        chk("t1_fin", {63'd0, a_fin}, 64'd1);
        chk("t1_fc", {32'd0, a_fc}, 64'd1);
        sv = 1'b0;
        cyc();
        chk("t1_valid_off", {63'd0, a_v0_64}, 64'd0);
        chk("t1_fin_hold", {63'd0, a_fin}, 64'd1);
        chk("t1_strobes", 64'(strb - s0), 64'd1);
        enable = 1'b0;
        cyc();
        chk("t1_fin_fall", {63'd0, a_fin}, 64'd0);

        // Gapped stream, two frames, saturating 32-bit path.
        ns = 32'd3; nf = 32'd2; sh = 6'd1;
        sx = 32'h7FFF_FFFF; sy = 32'h8000_0000;
        enable = 1'b1; sv = 1'b0;
        cyc();
        s0 = strb;
        for (int i = 0; i < 12; i++) begin
            sv = (i % 2 == 0);
            cyc();
            if (i == 4) begin
                chk("t2_f1_valid", {63'd0, a_v0_64}, 64'd1);
                chk("t2_f1_fc", {32'd0, a_fc}, 64'd1);
                chk("t2_f1_fin", {63'd0, a_fin}, 64'd0);
                chk("t2_f1_r0_64", a_r0_64, 64'h0000_0001_7FFF_FFFD);
                chk("t2_f1_r1_64", a_r1_64, 64'hFFFF_FFFE_8000_0000);
                chk("t2_f1_r0_32", {32'd0, a_r0_32}, 64'h0000_0000_7FFF_FFFF);
                chk("t2_f1_r1_32", {32'd0, a_r1_32}, 64'h0000_0000_8000_0000);
            end
            if (i == 10) begin
                chk("t2_f2_valid", {63'd0, a_v0_64}, 64'd1);
                chk("t2_f2_fc", {32'd0, a_fc}, 64'd2);
                chk("t2_f2_fin", {63'd0, a_fin}, 64'd1);
                chk("t2_f2_r0_64", a_r0_64, 64'h0000_0001_7FFF_FFFD);
            end
        end
        sv = 1'b1;
        repeat (4) cyc();
        chk("t2_strobes", 64'(strb - s0), 64'd2);
        chk("t2_done_fc", {32'd0, a_fc}, 64'd2);
        chk("t2_done_fin", {63'd0, a_fin}, 64'd1);
        enable = 1'b0; sv = 1'b0;
        cyc();
        chk("t2_fin_fall", {63'd0, a_fin}, 64'd0);

        // Abort mid-frame, then restart.
        ns = 32'd8; nf = 32'd0; sh = 6'd0;
        enable = 1'b1;
        cyc();
        chk("t3_fc_clear", {32'd0, a_fc}, 64'd0);
        s0 = strb;
        sx = 32'd7; sy = 32'd7; sv = 1'b1;
        repeat (5) cyc();
        enable = 1'b0;
        cyc();
        sv = 1'b0;
        cyc();
        chk("t3_abort_strobes", 64'(strb - s0), 64'd0);
        chk("t3_abort_hold", a_r0_64, 64'h0000_0001_7FFF_FFFD);
        enable = 1'b1;
        cyc();
        sx = 32'd2; sy = 32'd2; sv = 1'b1;
        repeat (7) cyc();
        chk("t3_early_valid", {63'd0, a_v0_64}, 64'd0);
        cyc();
        chk("t3_valid", {63'd0, a_v0_64}, 64'd1);
        chk("t3_r0_64", a_r0_64, 64'd16);
        chk("t3_r1_32", {32'd0, a_r1_32}, 64'd16);
        chk("t3_fc", {32'd0, a_fc}, 64'd1);
        chk("t3_fin", {63'd0, a_fin}, 64'd0);

        // Mid-run parameter change has no effect; then clear beats frame end.
        ns = 32'd2; sx = 32'd1; sy = 32'd1;
        repeat (2) cyc();
        chk("t4_param_ignored", {63'd0, a_v0_64}, 64'd0);
        enable = 1'b0; sv = 1'b0;
        cyc();
        enable = 1'b1;
        cyc();
        sx = 32'd5; sy = 32'd5; sv = 1'b1;
        cyc();
        rfc = 1'b1;
        cyc();
        chk("t4_clr_valid", {63'd0, a_v0_64}, 64'd0);
        chk("t4_clr_r0_64", a_r0_64, 64'd0);
        chk("t4_clr_r1_64", a_r1_64, 64'd0);
        chk("t4_clr_r0_32", {32'd0, a_r0_32}, 64'd0);
        chk("t4_clr_fc", {32'd0, a_fc}, 64'd0);
        rfc = 1'b0; sx = 32'd9; sy = 32'd9;
        cyc();
        chk("t4_entry_valid", {63'd0, a_v0_64}, 64'd0);
        sx = 32'd1; sy = 32'd1;
        cyc();
        cyc();
        chk("t4_restart_valid", {63'd0, a_v0_64}, 64'd1);
        chk("t4_restart_r0_64", a_r0_64, 64'd2);
        enable = 1'b0; sv = 1'b0;
        cyc();

        // n_samples = 0 acts as 1: strobe on every sample.
        ns = 32'd0; nf = 32'd0;
        enable = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            sx = vals[k]; sy = 32'd0 - vals[k]; sv = 1'b1;
            cyc();
            chk("t5_valid", {63'd0, a_v0_64}, 64'd1);
            chk("t5_r0_64", a_r0_64, sext(vals[k]));
            chk("t5_r1_64", a_r1_64, sext(32'd0 - vals[k]));
            chk("t5_fc", {32'd0, a_fc}, 64'(k + 1));
        end
        sv = 1'b0; enable = 1'b0;
        cyc();

        // Overflow on the 34-bit instance: fifth 0x7FFFFFFF wraps past 2^33-1.
        rfc = 1'b1;
        cyc();
        rfc = 1'b0;
        chk("t6_ovf_init", {63'd0, b_ovf}, 64'd0);
        ns = 32'hFFFF_FFFF; nf = 32'd0;
        enable = 1'b1;
        cyc();
        sx = 32'h7FFF_FFFF; sy = 32'd0; sv = 1'b1;
        repeat (4) cyc();
        chk("t6_ovf_before", {63'd0, b_ovf}, 64'd0);
        cyc();
        chk("t6_ovf_set", {63'd0, b_ovf}, 64'd1);
        chk("t6_wide_no_ovf", {63'd0, a_ovf}, 64'd0);
        repeat (3) cyc();
        sv = 1'b0; enable = 1'b0;
        cyc();
        chk("t6_ovf_sticky", {63'd0, b_ovf}, 64'd1);
        rfc = 1'b1;
        cyc();
        rfc = 1'b0;
        chk("t6_ovf_clear", {63'd0, b_ovf}, 64'd0);

        // Asynchronous reset pulse between edges mid-ACCUM.
        ns = 32'd4; nf = 32'd0; sh = 6'd0;
        enable = 1'b1; sx = 32'd1; sy = 32'd1; sv = 1'b1;
        cyc();
        repeat (4) cyc();
        chk("t7_pre_valid", {63'd0, a_v0_64}, 64'd1);
        chk("t7_pre_r0_64", a_r0_64, 64'd4);
        repeat (2) cyc();
        #2 reset_n = 1'b0;
        #1;
        chk("t7_async_r0_64", a_r0_64, 64'd0);
        chk("t7_async_fc", {32'd0, a_fc}, 64'd0);
        chk("t7_async_r0_32", {32'd0, a_r0_32}, 64'd0);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t7_resume_valid", {63'd0, a_v0_64}, (k == 4) ? 64'd1 : 64'd0);
        end
        chk("t7_resume_r0_64", a_r0_64, 64'd4);
        sv = 1'b0; enable = 1'b0;
        cyc();
        chk("valids_agree", 64'(vbad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
